pipeline_hazard_unit: RTL and testbench

Parametrised hazard and forwarding controller for the pipelined LEGv8 core. It tracks the destination of every in-flight instruction across DEPTH post-decode stages and produces the per-operand forwarding selects consumed by the decode stage, `FW_RegFile1_Ctrl` and `FW_RegFile2_Ctrl`. It also produces a load-use stall, the fetch flush on taken branches, and saturating stall/flush event counters. The default configuration (DEPTH=2, LOAD_READY_STAGE=1) reproduces the current EX/MEM forwarding scheme; larger DEPTH supports deeper pipelines and longer-latency loads.

---
 rtl/pipeline_hazard_unit_if.sv | 35 +++
 rtl/pipeline_hazard_unit.sv | 109 ++++++++++
 tb/tb_pipeline_hazard_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_unit_if.sv
// Decode-side bundle of the hazard/forwarding controller: operand info in,
// forwarding selects, stall/flush and event counters out.
interface pipeline_hazard_unit_if #(
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              br_taken;
  logic [SEL_W-1:0]  fw1_sel;
  logic [SEL_W-1:0]  fw2_sel;
  logic              stall;
  logic              if_flush;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_regwrite, id_memread, br_taken,
    input  fw1_sel, fw2_sel, stall, if_flush, stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_regwrite, id_memread, br_taken,
    output fw1_sel, fw2_sel, stall, if_flush, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Tracks destinations of in-flight instructions over DEPTH post-decode stages
// and derives forwarding selects, load-use stall, fetch flush and event counts.
module pipeline_hazard_unit #(
  parameter int DEPTH            = 2,
  parameter int REG_AW           = 5,
  parameter int ZERO_REG         = 31,
  parameter int LOAD_READY_STAGE = 1,
  parameter int CNT_W            = 16,
  parameter int SEL_W            = $clog2(DEPTH + 1)
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_unit_if.slave hz
);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  regwrite_q, regwrite_d;
  logic [DEPTH-1:0]  memread_q, memread_d;
  logic [REG_AW-1:0] rd_q [DEPTH];
  logic [REG_AW-1:0] rd_d [DEPTH];
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic [DEPTH-1:0]  match1, match2;
  logic              src1_live, src2_live;
  logic [SEL_W:0]    res1, res2;
  logic              stall;

  // Gating on reset keeps selects and stall quiet while reset is held.
  assign src1_live = ~reset & hz.id_valid & hz.id_rs1_used & (hz.id_rs1 != REG_AW'(ZERO_REG));
  assign src2_live = ~reset & hz.id_valid & hz.id_rs2_used & (hz.id_rs2 != REG_AW'(ZERO_REG));

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match1[gi] = src1_live & valid_q[gi] & regwrite_q[gi] & (rd_q[gi] == hz.id_rs1);
      assign match2[gi] = src2_live & valid_q[gi] & regwrite_q[gi] & (rd_q[gi] == hz.id_rs2);
    end
  endgenerate

  // Returns {hazard, select}; only the youngest match is considered, so a
  // not-yet-ready load can never fall through to an older producer.
  function automatic logic [SEL_W:0] resolve(input logic [DEPTH-1:0] m,
                                             input logic [DEPTH-1:0] mr);
    logic [SEL_W-1:0] sel;
    logic             haz;
    logic             found;
    sel   = '0;
    haz   = 1'b0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i] && !found) begin
        found = 1'b1;
        if (mr[i] && (i < LOAD_READY_STAGE)) haz = 1'b1;
        else                                  sel = SEL_W'(i + 1);
      end
    end
    return {haz, sel};
  endfunction

  assign res1  = resolve(match1, memread_q);
  assign res2  = resolve(match2, memread_q);
  assign stall = res1[SEL_W] | res2[SEL_W];

  assign hz.fw1_sel     = res1[SEL_W-1:0];
  assign hz.fw2_sel     = res2[SEL_W-1:0];
  assign hz.stall       = stall;
  assign hz.if_flush    = hz.br_taken & hz.id_valid & ~stall;
  assign hz.stall_count = stall_cnt_q;
  assign hz.flush_count = flush_cnt_q;

  always_comb begin
    valid_d[0]    = hz.id_valid & ~stall;
    regwrite_d[0] = hz.id_regwrite;
    memread_d[0]  = hz.id_memread;
    rd_d[0]       = hz.id_rd;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i]    = valid_q[i-1];
      regwrite_d[i] = regwrite_q[i-1];
      memread_d[i]  = memread_q[i-1];
      rd_d[i]       = rd_q[i-1];
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1))       stall_cnt_d = stall_cnt_q + 1'b1;
    if (hz.if_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      regwrite_q  <= '0;
      memread_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) rd_q[i] <= '0;
    end else begin
      valid_q     <= valid_d;
      regwrite_q  <= regwrite_d;
      memread_q   <= memread_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      for (int i = 0; i < DEPTH; i++) rd_q[i] <= rd_d[i];
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench: driver pushes hand-computed expectations per decode cycle,
// a negedge monitor pops and compares against the selected instance.
module tb_pipeline_hazard_unit;

  localparam int N = -1;  // "don't check" marker

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_unit_if #(.REG_AW(5), .SEL_W(2), .CNT_W(16)) ia ();
  pipeline_hazard_unit_if #(.REG_AW(5), .SEL_W(3), .CNT_W(4))  ib ();

  pipeline_hazard_unit #(.DEPTH(2), .REG_AW(5), .ZERO_REG(31), .LOAD_READY_STAGE(1),
                         .CNT_W(16), .SEL_W(2))
    dut_a (.clk(clk), .reset(rst_a), .hz(ia.slave));

  pipeline_hazard_unit #(.DEPTH(4), .REG_AW(5), .ZERO_REG(31), .LOAD_READY_STAGE(3),
                         .CNT_W(4), .SEL_W(3))
    dut_b (.clk(clk), .reset(rst_b), .hz(ib.slave));

  typedef struct {
    string nm;
    int    dut;
    int    fw1, fw2, st, fl, sc, fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input string field, input int act, input int expv);
    if (expv < 0) return;
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d, expected %0d", nm, field, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      int a1, a2, ast, afl, asc, afc;
      e = exp_q.pop_front();
      if (e.dut == 0) begin
        a1 = int'(ia.fw1_sel); a2 = int'(ia.fw2_sel); ast = int'(ia.stall);
        afl = int'(ia.if_flush); asc = int'(ia.stall_count); afc = int'(ia.flush_count);
      end else begin
        a1 = int'(ib.fw1_sel); a2 = int'(ib.fw2_sel); ast = int'(ib.stall);
        afl = int'(ib.if_flush); asc = int'(ib.stall_count); afc = int'(ib.flush_count);
      end
      chk(e.nm, "fw1_sel", a1, e.fw1);
      chk(e.nm, "fw2_sel", a2, e.fw2);
      chk(e.nm, "stall", ast, e.st);
      chk(e.nm, "if_flush", afl, e.fl);
      chk(e.nm, "stall_count", asc, e.sc);
      chk(e.nm, "flush_count", afc, e.fc);
      $display("[TB] %s dut=%0d fw1=%0d fw2=%0d stall=%0d flush=%0d sc=%0d fc=%0d",
               e.nm, e.dut, a1, a2, ast, afl, asc, afc);
    end
  end

  task automatic drive_idle_a();
    ia.id_valid = 1'b0; ia.id_rs1 = '0; ia.id_rs2 = '0; ia.id_rs1_used = 1'b0;
    ia.id_rs2_used = 1'b0; ia.id_rd = '0; ia.id_regwrite = 1'b0;
    ia.id_memread = 1'b0; ia.br_taken = 1'b0;
  endtask

  task automatic drive_idle_b();
    ib.id_valid = 1'b0; ib.id_rs1 = '0; ib.id_rs2 = '0; ib.id_rs1_used = 1'b0;
    ib.id_rs2_used = 1'b0; ib.id_rd = '0; ib.id_regwrite = 1'b0;
    ib.id_memread = 1'b0; ib.br_taken = 1'b0;
  endtask

  // One decode cycle on the chosen instance plus its expected response.
  task automatic step(input int dut, input string nm, input bit rst, input bit v,
                      input int rs1, input bit u1, input int rs2, input bit u2,
                      input int rd, input bit rw, input bit mr, input bit br,
                      input int e1, input int e2, input int est, input int efl,
                      input int esc, input int efc);
    exp_t e;
    if (dut == 0) begin
      drive_idle_b();
      rst_a = rst;
      ia.id_valid = v; ia.id_rs1 = 5'(rs1); ia.id_rs2 = 5'(rs2);
      ia.id_rs1_used = u1; ia.id_rs2_used = u2; ia.id_rd = 5'(rd);
      ia.id_regwrite = rw; ia.id_memread = mr; ia.br_taken = br;
    end else begin
      drive_idle_a();
      rst_b = rst;
      ib.id_valid = v; ib.id_rs1 = 5'(rs1); ib.id_rs2 = 5'(rs2);
      ib.id_rs1_used = u1; ib.id_rs2_used = u2; ib.id_rd = 5'(rd);
      ib.id_regwrite = rw; ib.id_memread = mr; ib.br_taken = br;
    end
    e.nm = nm; e.dut = dut; e.fw1 = e1; e.fw2 = e2; e.st = est;
    e.fl = efl; e.sc = esc; e.fc = efc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_sc;
    drive_idle_a();
    drive_idle_b();
    @(posedge clk);
    #1;

    // ---------------- default configuration ----------------
    //   dut nm            rst v  rs1 u1 rs2 u2 rd rw mr br  fw1 fw2 st fl sc fc
    step(0, "a_reset0",     1, 1,  1, 1,  2, 1,  1, 1, 0, 1,  0,  0, 0, 1, N, N);
    step(0, "a_reset1",     1, 1,  1, 1,  2, 1,  1, 1, 0, 1,  0,  0, 0, 1, 0, 0);
    step(0, "alu_prod",     0, 1, 10, 1, 11, 1,  1, 1, 0, 0,  0,  0, 0, 0, 0, 0);
    step(0, "alu_chain",    0, 1,  1, 1,  1, 1,  2, 1, 0, 0,  1,  1, 0, 0, 0, 0);
    step(0, "indep",        0, 1, 12, 1, 13, 1,  7, 1, 0, 0,  0,  0, 0, 0, 0, 0);
    step(0, "gap_one",      0, 1,  2, 1,  2, 1,  8, 1, 0, 0,  2,  2, 0, 0, 0, 0);
    step(0, "idle",         0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0,  0, 0, 0, 0, 0);
    step(0, "idle",         0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0,  0, 0, 0, 0, 0);
    step(0, "ldur",         0, 1, 20, 1,  0, 0,  3, 1, 1, 0,  0,  0, 0, 0, 0, 0);
    step(0, "load_use",     0, 1,  3, 1,  5, 1,  4, 1, 0, 0,  0,  0, 1, 0, 0, 0);
    step(0, "load_use_fwd", 0, 1,  3, 1,  5, 1,  4, 1, 0, 0,  2,  0, 0, 0, 1, 0);
    step(0, "idle",         0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0,  0, 0, 0, 1, 0);
    step(0, "idle",         0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0,  0, 0, 0, 1, 0);
    step(0, "w6_old",       0, 1,  0, 0,  0, 0,  6, 1, 0, 0,  0,  0, 0, 0, 1, 0);
    step(0, "w6_new",       0, 1,  0, 0,  0, 0,  6, 1, 0, 0,  0,  0, 0, 0, 1, 0);
    step(0, "youngest",     0, 1,  6, 1,  9, 1, 10, 1, 0, 0,  1,  0, 0, 0, 1, 0);
    step(0, "idle",         0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0,  0, 0, 0, 1, 0);
    step(0, "idle",         0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0,  0, 0, 0, 1, 0);
    step(0, "w6_alu",       0, 1,  0, 0,  0, 0,  6, 1, 0, 0,  0,  0, 0, 0, 1, 0);
    step(0, "w6_ld",        0, 1,  0, 0,  0, 0,  6, 1, 1, 0,  0,  0, 0, 0, 1, 0);
    step(0, "young_load",   0, 1,  6, 1,  6, 1, 10, 1, 0, 0,  0,  0, 1, 0, 1, 0);
    step(0, "young_ld_fwd", 0, 1,  6, 1,  6, 1, 10, 1, 0, 0,  2,  2, 0, 0, 2, 0);
    step(0, "idle",         0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0,  0, 0, 0, 2, 0);
    step(0, "idle",         0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0,  0, 0, 0, 2, 0);
    step(0, "zr_prod",      0, 1,  0, 0,  0, 0, 31, 1, 0, 0,  0,  0, 0, 0, 2, 0);
    step(0, "zr_cons",      0, 1, 31, 1, 31, 1, 11, 1, 0, 0,  0,  0, 0, 0, 2, 0);
    step(0, "nowr_prod",    0, 1,  0, 0,  0, 0, 12, 0, 0, 0,  0,  0, 0, 0, 2, 0);
    step(0, "nowr_cons",    0, 1, 12, 1, 11, 1, 13, 1, 0, 0,  0,  2, 0, 0, 2, 0);
    step(0, "unused_src",   0, 1, 13, 0, 13, 1,  0, 0, 0, 0,  0,  1, 0, 0, 2, 0);
    step(0, "idle",         0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0,  0, 0, 0, 2, 0);
    step(0, "idle",         0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0,  0, 0, 0, 2, 0);
    step(0, "br_free",      0, 1,  0, 0,  0, 0,  0, 0, 0, 1,  0,  0, 0, 1, 2, 0);
    step(0, "br_novalid",   0, 0,  0, 0,  0, 0,  0, 0, 0, 1,  0,  0, 0, 0, 2, 1);
    step(0, "ld_br",        0, 1,  0, 0,  0, 0, 14, 1, 1, 0,  0,  0, 0, 0, 2, 1);
    step(0, "br_stall",     0, 1, 14, 1,  0, 0,  0, 0, 0, 1,  0,  0, 1, 0, 2, 1);
    step(0, "br_issue",     0, 1, 14, 1,  0, 0,  0, 0, 0, 1,  2,  0, 0, 1, 3, 1);
    step(0, "idle",         0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0,  0, 0, 0, 3, 2);

    // ---------------- DEPTH=4, LOAD_READY_STAGE=3, CNT_W=4 ----------------
    step(1, "b_reset0",     1, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0,  0, 0, 0, 0, 0);
    step(1, "b_ld",         0, 1,  0, 0,  0, 0,  3, 1, 1, 0,  0,  0, 0, 0, 0, 0);
    step(1, "b_use_st0",    0, 1,  3, 1,  0, 0,  4, 1, 0, 0,  0,  0, 1, 0, 0, 0);
    step(1, "b_use_st1",    0, 1,  3, 1,  0, 0,  4, 1, 0, 0,  0,  0, 1, 0, 1, 0);
    step(1, "b_use_st2",    0, 1,  3, 1,  0, 0,  4, 1, 0, 0,  0,  0, 1, 0, 2, 0);
    step(1, "b_use_fwd",    0, 1,  3, 1,  0, 0,  4, 1, 0, 0,  4,  0, 0, 0, 3, 0);

    exp_sc = 3;
    for (int k = 0; k < 5; k++) begin
      step(1, "b_sat_ld",   0, 1,  0, 0,  0, 0,  3, 1, 1, 0,  0,  0, 0, 0, exp_sc, 0);
      for (int s = 0; s < 3; s++) begin
        step(1, "b_sat_st", 0, 1,  3, 1,  0, 0,  4, 1, 0, 0,  0,  0, 1, 0, exp_sc, 0);
        exp_sc = (exp_sc < 15) ? exp_sc + 1 : 15;
      end
      step(1, "b_sat_fwd",  0, 1,  3, 1,  0, 0,  4, 1, 0, 0,  4,  0, 0, 0, exp_sc, 0);
    end

    step(1, "b_mid_ld",     0, 1,  0, 0,  0, 0,  3, 1, 1, 0,  0,  0, 0, 0, 15, 0);
    step(1, "b_mid_st",     0, 1,  3, 1,  0, 0,  4, 1, 0, 0,  0,  0, 1, 0, 15, 0);
    step(1, "b_mid_rst",    1, 1,  3, 1,  0, 0,  4, 1, 0, 0,  0,  0, 0, 0, N, N);
    step(1, "b_post_rst",   0, 1,  3, 1,  0, 0,  4, 1, 0, 0,  0,  0, 0, 0, 0, 0);
    step(1, "b_post_rst2",  0, 1,  3, 1,  0, 0,  5, 1, 0, 0,  0,  0, 0, 0, 0, 0);

    drive_idle_a();
    drive_idle_b();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
